// File: rtl/counter_updown_param.sv
// Parametrised up/down counter with prescaler, wrap/saturate limits, clear, load,
// compare match and a registered terminal-count pulse.
module counter_updown_param #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               PRESCALE  = 1,
    parameter int               SATURATE  = 0
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             cmp_match
);

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    logic [PRE_W-1:0] pre, pre_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             step;
    logic             at_lim;

    // With PRESCALE=1 pre is stuck at 0 == PRE_LAST, so every enabled cycle steps.
    assign step   = en && (pre == PRE_LAST);
    assign at_lim = up_dn ? (count == CNT_MAX) : (count == '0);

    always_comb begin
        count_nxt = count;
        pre_nxt   = pre;
        tc_nxt    = 1'b0;
        if (clr) begin
            count_nxt = RESET_VAL;
            pre_nxt   = '0;
        end else if (load) begin
            count_nxt = load_val;
            pre_nxt   = '0;
        end else if (step) begin
            pre_nxt = '0;
            tc_nxt  = at_lim;
            if (at_lim)
                count_nxt = (SATURATE != 0) ? count : (up_dn ? '0 : CNT_MAX);
            else
                count_nxt = up_dn ? count + 1'b1 : count - 1'b1;
        end else if (en) begin
            pre_nxt = pre + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            count <= RESET_VAL;
            pre   <= '0;
            tc    <= 1'b0;
        end else begin
            count <= count_nxt;
            pre   <= pre_nxt;
            tc    <= tc_nxt;
        end
    end

    assign cmp_match = (count == cmp_val);

endmodule

// File: tb/tb_counter_updown_param.sv
// Directed bench for counter_updown_param: four instances cover wrap, saturate,
// prescale and priority/compare/async-reset behaviour.
module tb_counter_updown_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A: W4 wrap, P1
    logic       a_en = 0, a_clr = 0, a_load = 0, a_up = 1;
    logic [3:0] a_lv = 0, a_cv = 4'hF, a_cnt;
    logic       a_tc, a_cm;
    counter_updown_param #(.WIDTH(4), .RESET_VAL(4'h0), .PRESCALE(1), .SATURATE(0)) u_a (
        .clk(clk), .rst_async(rst), .en(a_en), .clr(a_clr), .load(a_load), .load_val(a_lv),
        .up_dn(a_up), .cmp_val(a_cv), .count(a_cnt), .tc(a_tc), .cmp_match(a_cm));

    // B: W4 saturate, P1
    logic       b_en = 0, b_clr = 0, b_load = 0, b_up = 0;
    logic [3:0] b_lv = 0, b_cv = 0, b_cnt;
    logic       b_tc, b_cm;
    counter_updown_param #(.WIDTH(4), .RESET_VAL(4'h0), .PRESCALE(1), .SATURATE(1)) u_b (
        .clk(clk), .rst_async(rst), .en(b_en), .clr(b_clr), .load(b_load), .load_val(b_lv),
        .up_dn(b_up), .cmp_val(b_cv), .count(b_cnt), .tc(b_tc), .cmp_match(b_cm));

    // C: W8 wrap, P3
    logic       c_en = 0, c_clr = 0, c_load = 0, c_up = 1;
    logic [7:0] c_lv = 0, c_cv = 0, c_cnt;
    logic       c_tc, c_cm;
    counter_updown_param #(.WIDTH(8), .RESET_VAL(8'h00), .PRESCALE(3), .SATURATE(0)) u_c (
        .clk(clk), .rst_async(rst), .en(c_en), .clr(c_clr), .load(c_load), .load_val(c_lv),
        .up_dn(c_up), .cmp_val(c_cv), .count(c_cnt), .tc(c_tc), .cmp_match(c_cm));

    // D: W8 reset value 0x10, P1
    logic       d_en = 0, d_clr = 0, d_load = 0, d_up = 1;
    logic [7:0] d_lv = 0, d_cv = 8'h10, d_cnt;
    logic       d_tc, d_cm;
    counter_updown_param #(.WIDTH(8), .RESET_VAL(8'h10), .PRESCALE(1), .SATURATE(0)) u_d (
        .clk(clk), .rst_async(rst), .en(d_en), .clr(d_clr), .load(d_load), .load_val(d_lv),
        .up_dn(d_up), .cmp_val(d_cv), .count(d_cnt), .tc(d_tc), .cmp_match(d_cm));

    // expected sequences, one entry per edge
    logic [3:0] b_exp_cnt [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
    logic       b_exp_tc  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] c_exp_cnt [6] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
    logic [7:0] d_exp_cnt [5] = '{8'h04, 8'h05, 8'h06, 8'h05, 8'h04};
    logic       d_exp_cm  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        // reset state
        tick();
        chk("rst_a_cnt", 32'(a_cnt), 32'h0);
        chk("rst_a_tc",  32'(a_tc),  32'h0);
        chk("rst_a_cm",  32'(a_cm),  32'h0);
        chk("rst_d_cnt", 32'(d_cnt), 32'h10);
        chk("rst_d_cm",  32'(d_cm),  32'h1);
        rst = 1'b0;

        // A: count up through wrap
        a_en = 1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("a_cnt%0d", i), 32'(a_cnt), 32'(i % 16));
            chk($sformatf("a_tc%0d", i),  32'(a_tc),  32'(i == 16));
            chk($sformatf("a_cm%0d", i),  32'(a_cm),  32'(i == 15));
        end
        a_en = 0;
        tick();
        chk("a_hold_cnt", 32'(a_cnt), 32'h0);
        chk("a_hold_tc",  32'(a_tc),  32'h0);

        // B: load 2, step down into saturation
        b_load = 1; b_lv = 4'd2;
        tick();
        chk("b_load_cnt", 32'(b_cnt), 32'd2);
        b_load = 0; b_en = 1; b_up = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("b_cnt%0d", i), 32'(b_cnt), 32'(b_exp_cnt[i]));
            chk($sformatf("b_tc%0d", i),  32'(b_tc),  32'(b_exp_tc[i]));
        end
        b_en = 0;
        tick();
        chk("b_idle_tc", 32'(b_tc), 32'h0);

        // C: prescale by 3, with en dropped mid-interval
        c_en = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("c_cnt%0d", i), 32'(c_cnt), 32'(c_exp_cnt[i]));
        end
        tick();
        chk("c_pre1_cnt", 32'(c_cnt), 32'd2);
        c_en = 0;
        tick(); tick();
        chk("c_frozen_cnt", 32'(c_cnt), 32'd2);
        c_en = 1;
        tick();
        chk("c_resume1_cnt", 32'(c_cnt), 32'd2);
        tick();
        chk("c_resume2_cnt", 32'(c_cnt), 32'd3);
        chk("c_tc", 32'(c_tc), 32'h0);
        // load mid-interval restarts the full interval
        tick();
        c_load = 1; c_lv = 8'h40;
        tick();
        chk("c_load_cnt", 32'(c_cnt), 32'h40);
        c_load = 0;
        tick(); tick();
        chk("c_restart_hold", 32'(c_cnt), 32'h40);
        tick();
        chk("c_restart_step", 32'(c_cnt), 32'h41);
        c_en = 0;

        // D: priority clr > load > step
        d_en = 1; d_up = 1;
        tick();
        chk("d_step_cnt", 32'(d_cnt), 32'h11);
        d_clr = 1; d_load = 1; d_lv = 8'hA5;
        tick();
        chk("d_clr_cnt", 32'(d_cnt), 32'h10);
        chk("d_clr_tc",  32'(d_tc),  32'h0);
        d_clr = 0;
        tick();
        chk("d_load_cnt", 32'(d_cnt), 32'hA5);
        // compare and direction change
        d_cv = 8'h05; d_lv = 8'h03;
        tick();
        chk("d_load3_cnt", 32'(d_cnt), 32'h03);
        chk("d_load3_cm",  32'(d_cm),  32'h0);
        d_load = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("d_cnt%0d", i), 32'(d_cnt), 32'(d_exp_cnt[i]));
            chk($sformatf("d_cm%0d", i),  32'(d_cm),  32'(d_exp_cm[i]));
            if (i == 2) d_up = 0;
        end
        // async reset between edges at 0x37
        d_load = 1; d_lv = 8'h37; d_en = 0;
        tick();
        d_load = 0;
        chk("d_pre_rst_cnt", 32'(d_cnt), 32'h37);
        #3;
        rst = 1'b1;
        #1;
        chk("d_arst_cnt", 32'(d_cnt), 32'h10);
        chk("d_arst_tc",  32'(d_tc),  32'h0);
        chk("d_arst_cm",  32'(d_cm),  32'h0);
        tick();
        rst = 1'b0;
        d_en = 1; d_up = 1;
        tick();
        chk("d_post_rst_cnt", 32'(d_cnt), 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
